// File: rtl/hb_pkg.sv
// Hummingbird-1 shared types and 16-bit block cipher primitives.
// Used by both the transmit encryptor and the receive decryptor.
package hb_pkg;

  typedef logic [15:0]  word_t;
  typedef logic [63:0]  subkey_t;
  typedef logic [255:0] key_t;

  // RS1 sits in the low bits so a nonce casts directly to RS1..RS4.
  typedef struct packed {
    word_t rs4;
    word_t rs3;
    word_t rs2;
    word_t rs1;
  } rs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int INIT_RNDS = 4;
  localparam int RND_W     = 2;

  localparam int K1_LO = 0;
  localparam int K2_LO = 64;
  localparam int K3_LO = 128;
  localparam int K4_LO = 192;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic word_t rotl(input word_t x,
                                 input int unsigned n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic word_t sub_w(input word_t x);
    return {sbox(x[15:12]), sbox(x[11:8]),
            sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  function automatic word_t sub_inv_w(input word_t x);
    return {sbox_inv(x[15:12]), sbox_inv(x[11:8]),
            sbox_inv(x[7:4]), sbox_inv(x[3:0])};
  endfunction

  function automatic word_t lin(input word_t x);
    return x ^ rotl(x, 6) ^ rotl(x, 10);
  endfunction

  // lin has order 4, so its inverse is lin^3 expanded.
  function automatic word_t lin_inv(input word_t x);
    return x ^ rotl(x, 2) ^ rotl(x, 4)
             ^ rotl(x, 12) ^ rotl(x, 14);
  endfunction

  function automatic word_t enc_k(input word_t x,
                                  input subkey_t k);
    word_t y;
    y = x;
    for (int r = 0; r < 4; r++) begin
      y = lin(sub_w(y ^ k[16*r +: 16]));
    end
    return y ^ k[15:0] ^ k[47:32];
  endfunction

  function automatic word_t dec_k(input word_t x,
                                  input subkey_t k);
    word_t y;
    y = x ^ k[15:0] ^ k[47:32];
    for (int r = 3; r >= 0; r--) begin
      y = sub_inv_w(lin_inv(y)) ^ k[16*r +: 16];
    end
    return y;
  endfunction

endpackage

// File: rtl/hb_rx_datapath.sv
// Combinational Hummingbird-1 receive datapath.
// Produces plaintext, post-word RS, and next init-round RS.
module hb_rx_datapath
  import hb_pkg::*;
(
  input  rs_t   i_rs,
  input  key_t  i_key,
  input  word_t i_c,
  output word_t o_p,
  output rs_t   o_rs_run,
  output rs_t   o_rs_init
);

  subkey_t w_k1, w_k2, w_k3, w_k4;
  word_t   w_v12, w_v23, w_v34;
  word_t   w_rs1n, w_rs2n, w_rs3n, w_rs4n;
  word_t   w_i12, w_i23, w_i34, w_iv;

  assign w_k1 = i_key[K1_LO +: 64];
  assign w_k2 = i_key[K2_LO +: 64];
  assign w_k3 = i_key[K3_LO +: 64];
  assign w_k4 = i_key[K4_LO +: 64];

  assign w_v34 = dec_k(i_c, w_k4) - i_rs.rs4;
  assign w_v23 = dec_k(w_v34, w_k3) - i_rs.rs3;
  assign w_v12 = dec_k(w_v23, w_k2) - i_rs.rs2;
  assign o_p   = dec_k(w_v12, w_k1) - i_rs.rs1;

  assign w_rs1n = i_rs.rs1 + w_v34;
  assign w_rs3n = i_rs.rs3 + w_v23
                + w_v34 + w_rs1n;
  assign w_rs2n = i_rs.rs2 + w_v12 + w_rs3n;
  assign w_rs4n = i_rs.rs4 + w_rs1n;

  assign o_rs_run = {w_rs4n, w_rs3n,
                     w_rs2n, w_rs1n};

  assign w_i12 = enc_k(i_rs.rs1 + i_rs.rs3, w_k1);
  assign w_i23 = enc_k(i_rs.rs2 + w_i12, w_k2);
  assign w_i34 = enc_k(i_rs.rs3 + w_i23, w_k3);
  assign w_iv  = enc_k(i_rs.rs4 + w_i34, w_k4);

  assign o_rs_init = {i_rs.rs4 + w_iv,
                      i_rs.rs3 + w_i23,
                      i_rs.rs2 + w_i12,
                      i_rs.rs1 + w_i34};

endmodule

// File: rtl/humming_rx_decryptor.sv
// Hummingbird-1 receive-side stream decryptor.
// Session FSM, RS state, one-deep output register, word counter.
module humming_rx_decryptor
  import hb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [255:0]     key,
  input  logic [63:0]      nonce,
  input  logic             start,
  output logic             init_done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic [CNT_W-1:0] word_cnt
);

  state_t           r_state, w_state_n;
  logic [RND_W-1:0] r_rnd;
  rs_t              r_rs;
  logic             r_init_done;
  logic             r_m_valid;
  word_t            r_m_data;
  logic [CNT_W-1:0] r_cnt;

  word_t w_p;
  rs_t   w_rs_run, w_rs_init;
  logic  w_last_rnd, w_accept, w_drain;

  hb_rx_datapath u_dp (
    .i_rs      (r_rs),
    .i_key     (key),
    .i_c       (s_data),
    .o_p       (w_p),
    .o_rs_run  (w_rs_run),
    .o_rs_init (w_rs_init)
  );

  assign w_last_rnd = (r_rnd == RND_W'(INIT_RNDS - 1));
  assign s_ready    = (r_state == ST_RUN)
                   && (!r_m_valid || m_ready);
  assign w_accept   = s_valid && s_ready;
  assign w_drain    = r_m_valid && m_ready;

  // Session state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // Next state; start always wins and restarts init.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE: w_state_n = ST_IDLE;
      ST_INIT: if (w_last_rnd) w_state_n = ST_RUN;
      ST_RUN:  w_state_n = ST_RUN;
      default: w_state_n = ST_IDLE;
    endcase
    if (start) w_state_n = ST_INIT;
  end

  // RS load on start, init rounds, per-word update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs  <= '0;
      r_rnd <= '0;
    end else if (start) begin
      r_rs  <= rs_t'(nonce);
      r_rnd <= '0;
    end else if (r_state == ST_INIT) begin
      r_rs  <= w_rs_init;
      r_rnd <= r_rnd + RND_W'(1);
    end else if (w_accept) begin
      r_rs  <= w_rs_run;
    end
  end

  // Init-done flag, raised when the last round completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_init_done <= 1'b0;
    else if (start)
      r_init_done <= 1'b0;
    else if (r_state == ST_INIT && w_last_rnd)
      r_init_done <= 1'b1;
  end

  // Output register; refills on the same edge it drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (start) begin
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_p;
    end else if (w_drain) begin
      r_m_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (start)
      r_cnt <= '0;
    else if (w_drain)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign init_done = r_init_done;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_humming_rx_decryptor.sv
// Directed bench for humming_rx_decryptor.
// Transmit-side encryptor model feeds ciphertext; plaintext is checked.
module tb_humming_rx_decryptor;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] key = {4{64'h0123456789ABCDEF}};
  logic [63:0]  nonce = '0;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [15:0]  s_data = '0;
  logic         m_ready = 1'b0;
  logic         init_done, s_ready, m_valid;
  logic [15:0]  m_data, word_cnt;
  logic         init_done4, s_ready4, m_valid4;
  logic [15:0]  m_data4;
  logic [3:0]   word_cnt4;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] ct [0:299];
  logic [15:0] pt [0:299];
  logic [15:0] g_rs [0:3];

  logic [3:0] SB [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB,
                            4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8,
                            4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  humming_rx_decryptor #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .key(key),
    .nonce(nonce), .start(start),
    .init_done(init_done), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .word_cnt(word_cnt)
  );

  humming_rx_decryptor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .key(key),
    .nonce(nonce), .start(start),
    .init_done(init_done4), .s_valid(s_valid),
    .s_ready(s_ready4), .s_data(s_data),
    .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .word_cnt(word_cnt4)
  );

  function automatic logic [15:0] m_rot(
      input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] m_e(
      input logic [15:0] x, input logic [63:0] k);
    logic [15:0] y;
    y = x;
    for (int r = 0; r < 4; r++) begin
      y = y ^ k[16*r +: 16];
      y = {SB[y[15:12]], SB[y[11:8]],
           SB[y[7:4]], SB[y[3:0]]};
      y = y ^ m_rot(y, 6) ^ m_rot(y, 10);
    end
    return y ^ k[15:0] ^ k[47:32];
  endfunction

  task automatic gen(input logic [63:0] nc,
                     input int n,
                     input logic [15:0] base);
    logic [15:0] r1, r2, r3, r4;
    logic [15:0] v12, v23, v34, v;
    logic [63:0] k1, k2, k3, k4;
    k1 = key[63:0];    k2 = key[127:64];
    k3 = key[191:128]; k4 = key[255:192];
    r1 = nc[15:0];  r2 = nc[31:16];
    r3 = nc[47:32]; r4 = nc[63:48];
    for (int i = 0; i < 4; i++) begin
      v12 = m_e(r1 + r3, k1);
      v23 = m_e(r2 + v12, k2);
      v34 = m_e(r3 + v23, k3);
      v   = m_e(r4 + v34, k4);
      r1 = r1 + v34; r2 = r2 + v12;
      r3 = r3 + v23; r4 = r4 + v;
    end
    g_rs[0] = r1; g_rs[1] = r2;
    g_rs[2] = r3; g_rs[3] = r4;
    for (int i = 0; i < n; i++) begin
      pt[i] = base + 16'(i);
      v12 = m_e(pt[i] + r1, k1);
      v23 = m_e(v12 + r2, k2);
      v34 = m_e(v23 + r3, k3);
      ct[i] = m_e(v34 + r4, k4);
      r1 = r1 + v34;
      r3 = r3 + v23 + v34 + r1;
      r2 = r2 + v12 + r3;
      r4 = r4 + r1;
    end
  endtask

  task automatic pulse_start(input logic [63:0] nc);
    @(negedge clk);
    nonce = nc; start = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; exp_cnt = '0;
  endtask

  task automatic wait_init;
    int n;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_wait s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic stream(input int n, input int duty);
    int si, oi, cyc;
    logic stall;
    logic [15:0] held;
    si = 0; oi = 0; cyc = 0;
    stall = 1'b0; held = '0;
    while (oi < n && cyc < 4000) begin
      @(negedge clk);
      s_valid = (si < n);
      s_data  = (si < n) ? ct[si] : 16'h0;
      m_ready = ($urandom_range(99) < duty);
      #1;
      checks++;
      if (word_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL cnt got=%0d want=%0d",
                 word_cnt, exp_cnt);
      end
      if (stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          failures++;
          $display("FAIL stall_hold v=%b d=%h want 1/%h",
                   m_valid, m_data, held);
        end
      end
      if (m_valid && !m_ready) begin
        checks++;
        if (s_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_stall got=%b want 0",
                   s_ready);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== pt[oi]) begin
          failures++;
          $display("FAIL data[%0d] got=%h want=%h",
                   oi, m_data, pt[oi]);
        end
        oi++; exp_cnt++;
      end
      if (s_valid && s_ready) si++;
      stall = m_valid && !m_ready;
      held  = m_data;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    checks++;
    if (oi != n || word_cnt !== exp_cnt
        || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end out=%0d cnt=%0d v=%b want %0d/%0d/0",
               oi, word_cnt, m_valid, n, exp_cnt);
    end
  endtask

  task automatic test_reset;
    logic bad;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({init_done, s_ready, m_valid} !== 3'b000
        || m_data !== 16'h0 || word_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_out got=%b%b%b %h %h want 000 0 0",
               init_done, s_ready, m_valid, m_data, word_cnt);
    end
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || m_valid !== 1'b0) bad = 1'b1;
    end
    s_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_ready got=1 want 0");
    end
  endtask

  task automatic test_init_timing;
    gen(64'h0003_0002_0001_0000, 256, 16'h0000);
    @(negedge clk);
    nonce = 64'h0003_0002_0001_0000;
    start = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
    m_ready = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (e == 4) s_valid = 1'b0;
      checks++;
      if (s_ready !== (e == 5) || init_done !== (e == 5)) begin
        failures++;
        $display("FAIL init_edge%0d rdy=%b done=%b want %b",
                 e, s_ready, init_done, (e == 5));
      end
    end
    exp_cnt = '0;
    checks++;
    if (dut.r_rs.rs1 !== g_rs[0] || dut.r_rs.rs2 !== g_rs[1]
        || dut.r_rs.rs3 !== g_rs[2] || dut.r_rs.rs4 !== g_rs[3]) begin
      failures++;
      $display("FAIL init_rs got=%h %h %h %h want=%h %h %h %h",
               dut.r_rs.rs1, dut.r_rs.rs2, dut.r_rs.rs3,
               dut.r_rs.rs4, g_rs[0], g_rs[1], g_rs[2], g_rs[3]);
    end
  endtask

  task automatic test_loopback;
    stream(256, 100);
    checks++;
    if (word_cnt !== 16'd256) begin
      failures++;
      $display("FAIL loop_cnt got=%0d want=256", word_cnt);
    end
  endtask

  task automatic test_backpressure;
    gen(64'h1234_5678_9ABC_DEF0, 200, 16'h1000);
    pulse_start(64'h1234_5678_9ABC_DEF0);
    wait_init;
    stream(200, 30);
  endtask

  task automatic test_restart;
    gen(64'hA5A5_0F0F_3C3C_FFFF, 11, 16'h2000);
    pulse_start(64'hA5A5_0F0F_3C3C_FFFF);
    wait_init;
    stream(10, 100);
    @(negedge clk);
    s_valid = 1'b1; s_data = ct[10]; m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== pt[10]) begin
      failures++;
      $display("FAIL pend got=%b/%h want 1/%h",
               m_valid, m_data, pt[10]);
    end
    pulse_start(64'h0BAD_F00D_1357_2468);
    #1;
    checks++;
    if (m_valid !== 1'b0 || word_cnt !== 16'h0
        || init_done !== 1'b0) begin
      failures++;
      $display("FAIL restart got v=%b c=%0d d=%b want 0/0/0",
               m_valid, word_cnt, init_done);
    end
    gen(64'h0BAD_F00D_1357_2468, 20, 16'h3000);
    wait_init;
    stream(20, 100);
  endtask

  task automatic test_mid_init_reset;
    logic bad;
    pulse_start(64'h1111_2222_3333_4444);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({init_done, s_ready, m_valid} !== 3'b000
        || word_cnt !== 16'h0 || dut.r_rs !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%b c=%0d rs=%h want 000/0/0",
               init_done, s_ready, m_valid, word_cnt, dut.r_rs);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL post_reset_ready got=1 want 0");
    end
  endtask

  task automatic test_wrap;
    gen(64'hFEDC_BA98_7654_3210, 17, 16'h4000);
    pulse_start(64'hFEDC_BA98_7654_3210);
    wait_init;
    stream(17, 100);
    checks++;
    if (word_cnt4 !== 4'd1 || word_cnt !== 16'd17) begin
      failures++;
      $display("FAIL wrap got=%0d/%0d want 1/17",
               word_cnt4, word_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_init_timing;
    test_loopback;
    test_backpressure;
    test_restart;
    test_mid_init_reset;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
